// File: rtl/rx_buffer.sv
// rx_buffer: MSB-first serial-to-parallel receiver with a one-word holding
// register, consumer handshake (valid/ack) and a sticky overrun flag.
//
//   state | meaning
//   EMPTY | dout holds no unacknowledged word, valid=0
//   FULL  | dout holds a word awaiting ack, valid=1
module rx_buffer #(
   parameter int WIDTH = 8
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         din,
   input  logic                                         en,
   input  logic                                         sync,
   input  logic                                         ack,
   output logic [WIDTH-1:0]                             dout,
   output logic                                         valid,
   output logic                                         overrun,
   output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] bit_cnt
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_shreg;
   logic [CW-1:0]    r_bit_cnt;
   logic [WIDTH-1:0] r_dout;
   logic             r_overrun;

   logic             w_accept;
   logic             w_complete;
   logic [WIDTH-1:0] w_word;
   logic             w_load;
   logic             w_set_ovr;
   logic             w_clr_ovr;

   // sync wins over en, so a bit presented on a realign edge is dropped
   assign w_accept   = en & ~sync;
   assign w_complete = w_accept & (r_bit_cnt == CW'(WIDTH - 1));
   if (WIDTH > 1) begin : g_word
      assign w_word = {r_shreg[WIDTH-2:0], din};
   end else begin : g_word1
      assign w_word = din;
   end

   // Shift register and bit counter for the partial word being assembled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shreg   <= '0;
         r_bit_cnt <= '0;
      end else if (sync) begin
         r_shreg   <= '0;
         r_bit_cnt <= '0;
      end else if (en) begin
         r_shreg   <= w_word;
         r_bit_cnt <= w_complete ? '0 : r_bit_cnt + CW'(1);
      end
   end

   // Holding FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and holding-register control
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_set_ovr   = 1'b0;
      w_clr_ovr   = 1'b0;
      case (r_state)
         EMPTY: begin
            if (w_complete) begin
               w_load      = 1'b1;
               w_state_nxt = FULL;
            end
         end
         FULL: begin
            w_clr_ovr = ack;
            if (ack && w_complete) begin
               w_load = 1'b1;
            end else if (ack) begin
               w_state_nxt = EMPTY;
            end else if (w_complete) begin
               w_set_ovr = 1'b1;
            end
         end
         default: w_state_nxt = EMPTY;
      endcase
   end

   // Holding register and sticky overrun; a drop on the same edge wins over clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dout    <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_load) begin
            r_dout <= w_word;
         end
         if (w_set_ovr) begin
            r_overrun <= 1'b1;
         end else if (w_clr_ovr) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign dout    = r_dout;
   assign valid   = (r_state == FULL);
   assign overrun = r_overrun;
   assign bit_cnt = r_bit_cnt;

endmodule
